// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: loadable word array behind an in-order,
// fixed-latency, stallable and flushable request/response pipeline.
module instr_fetch_mem #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 131072,
  parameter int unsigned LATENCY     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [INSTR_WIDTH-1:0] rsp_instr,
  output logic [1:0]             rsp_fault,
  input  logic                   flush,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data
);

  localparam int unsigned OFF_W = $clog2(INSTR_WIDTH / 8);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // bit0: misaligned, bit1: below base or past the last word
  function automatic logic [1:0] fault_of(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] idx;
    idx = (a - BASE_ADDR) >> OFF_W;
    fault_of[0] = (a[OFF_W-1:0] != '0);
    fault_of[1] = (a < BASE_ADDR) || (idx >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    word_idx = IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   vld_q [LATENCY];
  logic [1:0]             flt_q [LATENCY];
  logic [INSTR_WIDTH-1:0] dat_q [LATENCY];
  logic                   alive_q;

  logic                   stall;
  logic                   accept;
  logic [1:0]             req_fault;
  logic [1:0]             load_fault;
  logic [IDX_W-1:0]       req_idx;
  logic [IDX_W-1:0]       load_idx;

  assign stall      = rsp_valid && !rsp_ready;
  assign req_ready  = alive_q && !stall && !flush;
  assign accept     = req_valid && req_ready;
  assign req_fault  = fault_of(req_addr);
  assign load_fault = fault_of(load_addr);
  assign req_idx    = word_idx(req_addr);
  assign load_idx   = word_idx(load_addr);

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_fault = flt_q[LATENCY-1];
  assign rsp_instr = dat_q[LATENCY-1];

  // Program load port; contents are never reset
  always_ff @(posedge clock) begin
    if (load_en && (load_fault == 2'b00)) begin
      mem[load_idx] <= load_data;
    end
  end

  // Fetch pipeline; the array read at acceptance sees the pre-load word
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      alive_q <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        flt_q[i] <= 2'b00;
        dat_q[i] <= '0;
      end
    end else begin
      alive_q <= 1'b1;
      if (flush) begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
          vld_q[i] <= 1'b0;
        end
      end else if (!stall) begin
        vld_q[0] <= accept;
        flt_q[0] <= accept ? req_fault : 2'b00;
        dat_q[0] <= (accept && (req_fault == 2'b00)) ? mem[req_idx] : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          flt_q[i] <= flt_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: LATENCY=2, BASE_ADDR=0x80000000, DEPTH=16.
module tb_instr_fetch_mem;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_mem #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .DEPTH      (16),
    .LATENCY    (2),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] addrs [4];
  logic [1:0]  faults [3];

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

    // reset state
    tick(); tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_instr", rsp_instr, 0);
    check("rst_fault", rsp_fault, 0);
    resetn = 1'b1;
    tick();
    check("ready_after_rst", req_ready, 1);

    // program words 0..3
    for (int k = 0; k < 4; k++) begin
      load_en = 1'b1; load_addr = BASE + 32'(4 * k); load_data = 32'h11 * 32'(k + 1);
      tick();
    end
    load_en = 1'b0;

    // back-to-back fetch, two-cycle latency
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin req_valid = 1'b1; req_addr = BASE + 32'(4 * c); end
      else req_valid = 1'b0;
      tick();
      if (c == 0 || c == 5) check("burst_lat_valid", rsp_valid, 0);
      else begin
        check("burst_valid", rsp_valid, 1);
        check("burst_instr", rsp_instr, 32'h11 * 32'(c));
        check("burst_fault", rsp_fault, 0);
      end
    end

    // faults: misaligned, past end, below base
    addrs[0] = 32'h8000_0002; addrs[1] = 32'h8000_0040; addrs[2] = 32'h7FFF_FFFC;
    faults[0] = 2'b01; faults[1] = 2'b10; faults[2] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin req_valid = 1'b1; req_addr = addrs[c]; end
      else req_valid = 1'b0;
      tick();
      if (c >= 1) begin
        check("flt_valid", rsp_valid, 1);
        check("flt_code", rsp_fault, faults[c-1]);
        check("flt_instr", rsp_instr, 0);
      end
    end
    tick();
    check("flt_drain", rsp_valid, 0);

    // stall: three fetches, consumer blocked for five cycles
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = BASE;
    tick();
    req_addr = BASE + 32'd4;
    #1 check("stall_pre_ready", req_ready, 1);
    tick();
    req_addr = BASE + 32'd8;
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_instr", rsp_instr, 32'h11);
      check("stall_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("unstall_ready", req_ready, 1);
    check("unstall_instr", rsp_instr, 32'h11);
    tick();
    req_valid = 1'b0;
    check("stall_rsp1", rsp_instr, 32'h22);
    check("stall_rsp1_v", rsp_valid, 1);
    tick();
    check("stall_rsp2", rsp_instr, 32'h33);
    check("stall_rsp2_v", rsp_valid, 1);
    tick();
    check("stall_drain", rsp_valid, 0);

    // flush with two fetches in flight
    req_valid = 1'b1; req_addr = BASE;
    tick();
    req_addr = BASE + 32'd12;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    #1 check("flush_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_valid", rsp_valid, 0);
    tick();
    check("flush_no_stale", rsp_valid, 0);
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    tick();
    req_valid = 1'b0;
    check("post_flush_gap", rsp_valid, 0);
    tick();
    check("post_flush_valid", rsp_valid, 1);
    check("post_flush_instr", rsp_instr, 32'h22);
    tick();
    check("post_flush_only", rsp_valid, 0);

    // same-cycle load and fetch of word 2: read-first
    load_en = 1'b1; load_addr = BASE + 32'd8; load_data = 32'hAB;
    req_valid = 1'b1; req_addr = BASE + 32'd8;
    tick();
    load_en = 1'b0;
    tick();
    req_valid = 1'b0;
    check("rf_old", rsp_instr, 32'h33);
    tick();
    check("rf_new", rsp_instr, 32'hAB);
    check("rf_new_v", rsp_valid, 1);
    tick();

    // ignored loads: misaligned and out of range must not disturb word 1
    load_en = 1'b1; load_addr = BASE + 32'd5; load_data = 32'hDEAD;
    tick();
    load_addr = BASE + 32'h44;
    tick();
    load_en = 1'b0;
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    tick();
    req_valid = 1'b0;
    tick();
    check("bad_load_ignored", rsp_instr, 32'h22);
    tick();

    // reset mid-burst
    req_valid = 1'b1; req_addr = BASE;
    tick();
    req_addr = BASE + 32'd4;
    tick();
    check("pre_rst_valid", rsp_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", rsp_valid, 0);
    check("arst_instr", rsp_instr, 0);
    check("arst_ready", req_ready, 0);
    req_valid = 1'b0;
    tick(); tick();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    check("rel_ready", req_ready, 1);
    check("rel_valid", rsp_valid, 0);
    tick();
    check("rel_no_stale", rsp_valid, 0);
    tick();
    check("rel_no_stale2", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
